// File: rtl/mem_arbiter_if.sv
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : I-cache, D-cache and physical-memory bus bundle for
//                mem_arbiter. The arbiter uses the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128,
   parameter int CNT_W  = 16
);
   logic              iIRead;
   logic [ADDR_W-1:0] iIAddr;
   logic [LINE_W-1:0] oIRdata;
   logic              oIResp;
   logic              iDRead;
   logic              iDWrite;
   logic [ADDR_W-1:0] iDAddr;
   logic [LINE_W-1:0] iDWdata;
   logic [LINE_W-1:0] oDRdata;
   logic              oDResp;
   logic              oPmemRead;
   logic              oPmemWrite;
   logic [ADDR_W-1:0] oPmemAddr;
   logic [LINE_W-1:0] oPmemWdata;
   logic [LINE_W-1:0] iPmemRdata;
   logic              iPmemResp;
   logic [CNT_W-1:0]  oConflictCount;

   modport slave (
      input  iIRead, iIAddr, iDRead, iDWrite, iDAddr, iDWdata, iPmemRdata, iPmemResp,
      output oIRdata, oIResp, oDRdata, oDResp, oPmemRead, oPmemWrite, oPmemAddr,
             oPmemWdata, oConflictCount
   );

   modport master (
      output iIRead, iIAddr, iDRead, iDWrite, iDAddr, iDWdata, iPmemRdata, iPmemResp,
      input  oIRdata, oIResp, oDRdata, oDResp, oPmemRead, oPmemWrite, oPmemAddr,
             oPmemWdata, oConflictCount
   );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Serialises I-cache fills and D-cache fills/writebacks onto a
//                single physical-memory port. Define MEM_ARB_ROUND_ROBIN_EN
//                for alternating priority on conflicts (default: D first).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128,
   parameter int CNT_W  = 16
) (
   input  logic          iClk,
   input  logic          iRstN,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t            rState;
   logic              rPmemRead;
   logic              rPmemWrite;
   logic [ADDR_W-1:0] rPmemAddr;
   logic [LINE_W-1:0] rPmemWdata;
   logic [LINE_W-1:0] rIRdata;
   logic [LINE_W-1:0] rDRdata;
   logic              rIResp;
   logic              rDResp;
   logic [CNT_W-1:0]  rConflictCount;

   logic wDReq;
   logic wIReq;
   logic wConflict;
   logic wGrantD;

   assign wDReq     = bus.iDRead | bus.iDWrite;
   assign wIReq     = bus.iIRead;
   assign wConflict = wDReq & wIReq;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Set means I wins the next conflict; flips on every conflict grant.
   logic rPrioI;

   assign wGrantD = wDReq & ~(wConflict & rPrioI);

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         rPrioI <= 1'b0;
      end else if (rState == IDLE && wConflict) begin
         rPrioI <= ~rPrioI;
      end
   end
`else
   assign wGrantD = wDReq;
`endif

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         rState         <= IDLE;
         rPmemRead      <= 1'b0;
         rPmemWrite     <= 1'b0;
         rPmemAddr      <= '0;
         rPmemWdata     <= '0;
         rIRdata        <= '0;
         rDRdata        <= '0;
         rIResp         <= 1'b0;
         rDResp         <= 1'b0;
         rConflictCount <= '0;
      end else begin
         rIResp <= 1'b0;
         rDResp <= 1'b0;
         case (rState)
            IDLE: begin
               if (wConflict && rConflictCount != '1) begin
                  rConflictCount <= rConflictCount + CNT_W'(1);
               end
               // Command is latched here so pmem never sees live requester inputs.
               if (wGrantD) begin
                  rState    <= SERVE_D;
                  rPmemAddr <= bus.iDAddr;
                  if (bus.iDWrite) begin
                     rPmemWrite <= 1'b1;
                     rPmemWdata <= bus.iDWdata;
                  end else begin
                     rPmemRead <= 1'b1;
                  end
               end else if (wIReq) begin
                  rState    <= SERVE_I;
                  rPmemAddr <= bus.iIAddr;
                  rPmemRead <= 1'b1;
               end
            end
            SERVE_I, SERVE_D: begin
               if (bus.iPmemResp) begin
                  rPmemRead  <= 1'b0;
                  rPmemWrite <= 1'b0;
                  rState     <= DONE;
                  if (rState == SERVE_D) begin
                     rDRdata <= bus.iPmemRdata;
                     rDResp  <= 1'b1;
                  end else begin
                     rIRdata <= bus.iPmemRdata;
                     rIResp  <= 1'b1;
                  end
               end
            end
            DONE: begin
               rState <= IDLE;
            end
            default: begin
               rState <= IDLE;
            end
         endcase
      end
   end

   assign bus.oIRdata        = rIRdata;
   assign bus.oIResp         = rIResp;
   assign bus.oDRdata        = rDRdata;
   assign bus.oDResp         = rDResp;
   assign bus.oPmemRead      = rPmemRead;
   assign bus.oPmemWrite     = rPmemWrite;
   assign bus.oPmemAddr      = rPmemAddr;
   assign bus.oPmemWdata     = rPmemWdata;
   assign bus.oConflictCount = rConflictCount;

endmodule

`default_nettype wire
